// File: rtl/sap1_pkg.sv
// rtl/sap1_pkg.sv - shared opcodes, T-state encodings and control-word layout for the SAP-1 sequencer
package sap1_pkg;

  localparam int T_W = 6;

  typedef enum logic [3:0] {
    OP_LDA = 4'h0,
    OP_ADD = 4'h1,
    OP_SUB = 4'h2,
    OP_JMP = 4'h4,
    OP_JC  = 4'h5,
    OP_JZ  = 4'h6,
    OP_OUT = 4'hE,
    OP_HLT = 4'hF
  } opcode_e;

  localparam logic [T_W-1:0] T1 = 6'b000001;
  localparam logic [T_W-1:0] T2 = 6'b000010;
  localparam logic [T_W-1:0] T3 = 6'b000100;
  localparam logic [T_W-1:0] T4 = 6'b001000;
  localparam logic [T_W-1:0] T5 = 6'b010000;
  localparam logic [T_W-1:0] T6 = 6'b100000;

  localparam int CW_W   = 13;
  localparam int CW_CP  = 0;
  localparam int CW_EP  = 1;
  localparam int CW_NLM = 2;
  localparam int CW_ER  = 3;
  localparam int CW_NLI = 4;
  localparam int CW_EI  = 5;
  localparam int CW_NLA = 6;
  localparam int CW_EA  = 7;
  localparam int CW_NLB = 8;
  localparam int CW_EU  = 9;
  localparam int CW_SUB = 10;
  localparam int CW_NLO = 11;
  localparam int CW_NLP = 12;

  // Loads are active-low, so the idle word has every nL* bit set.
  localparam logic [CW_W-1:0] CW_INACTIVE = CW_W'((1 << CW_NLM) | (1 << CW_NLI) | (1 << CW_NLA) |
                                                 (1 << CW_NLB) | (1 << CW_NLO) | (1 << CW_NLP));

endpackage

// File: rtl/sap1_control_sequencer_if.sv
// rtl/sap1_control_sequencer_if.sv - control bus between the sequencer and the accumulator datapath
interface sap1_control_sequencer_if;
  import sap1_pkg::*;

  logic           run;
  logic [3:0]     ir_opcode;
  logic           CF;
  logic           ZF;
  logic           Cp;
  logic           Ep;
  logic           nLm;
  logic           Er;
  logic           nLi;
  logic           Ei;
  logic           nLa;
  logic           Ea;
  logic           nLb;
  logic           Eu;
  logic           sub;
  logic           nLo;
  logic           nLp;
  logic           halt;
  logic [T_W-1:0] t_state;

  modport master (
    input  run, ir_opcode, CF, ZF,
    output Cp, Ep, nLm, Er, nLi, Ei, nLa, Ea, nLb, Eu, sub, nLo, nLp, halt, t_state
  );

  modport slave (
    output run, ir_opcode, CF, ZF,
    input  Cp, Ep, nLm, Er, nLi, Ei, nLa, Ea, nLb, Eu, sub, nLo, nLp, halt, t_state
  );

endinterface

// File: rtl/sap1_ring_counter.sv
// rtl/sap1_ring_counter.sv - one-hot T-state ring with run enable and halt clear
module sap1_ring_counter #(
  parameter int N = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         run,
  input  logic         halt,
  output logic [N-1:0] t_state
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      t_state <= N'(1);
    end else if (halt) begin
      t_state <= '0;
    end else if (run) begin
      t_state <= {t_state[N-2:0], t_state[N-1]};
    end
  end

endmodule

// File: rtl/sap1_control_sequencer.sv
// rtl/sap1_control_sequencer.sv - microcoded T-cycle sequencer: flag latch, halt register and strobe decode
module sap1_control_sequencer
  import sap1_pkg::*;
#(
  parameter int T_STATES = 6
) (
  input  logic                       clk,
  input  logic                       rst,
  sap1_control_sequencer_if.master   bus
);

  logic [T_W-1:0]  t_state;
  logic            halt_q;
  logic            cf_q;
  logic            zf_q;
  logic            halt_req;
  logic [CW_W-1:0] cw;

  // The opcode is only valid once the IR has loaded, so HLT is acted on at the end of T4.
  assign halt_req = bus.run && !halt_q && (t_state == T4) && (bus.ir_opcode == OP_HLT);

  sap1_ring_counter #(.N(T_STATES)) u_ring (
    .clk     (clk),
    .rst     (rst),
    .run     (bus.run),
    .halt    (halt_req | halt_q),
    .t_state (t_state)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      halt_q <= 1'b0;
      cf_q   <= 1'b0;
      zf_q   <= 1'b0;
    end else begin
      if (halt_req) begin
        halt_q <= 1'b1;
      end
      if (bus.run && !halt_q && (t_state == T3)) begin
        cf_q <= bus.CF;
        zf_q <= bus.ZF;
      end
    end
  end

  always_comb begin
    cw = CW_INACTIVE;
    if (bus.run && !halt_q && !rst) begin
      case (t_state)
        T1: begin cw[CW_EP] = 1'b1; cw[CW_NLM] = 1'b0; end
        T2: cw[CW_CP] = 1'b1;
        T3: begin cw[CW_ER] = 1'b1; cw[CW_NLI] = 1'b0; end
        T4: begin
          case (bus.ir_opcode)
            OP_LDA, OP_ADD, OP_SUB: begin cw[CW_EI] = 1'b1; cw[CW_NLM] = 1'b0; end
            OP_OUT: begin cw[CW_EA] = 1'b1; cw[CW_NLO] = 1'b0; end
            OP_JMP: begin cw[CW_EI] = 1'b1; cw[CW_NLP] = 1'b0; end
            OP_JC:  if (cf_q) begin cw[CW_EI] = 1'b1; cw[CW_NLP] = 1'b0; end
            OP_JZ:  if (zf_q) begin cw[CW_EI] = 1'b1; cw[CW_NLP] = 1'b0; end
            default: ;
          endcase
        end
        T5: begin
          case (bus.ir_opcode)
            OP_LDA: begin cw[CW_ER] = 1'b1; cw[CW_NLA] = 1'b0; end
            OP_ADD: begin cw[CW_ER] = 1'b1; cw[CW_NLB] = 1'b0; end
            OP_SUB: begin cw[CW_ER] = 1'b1; cw[CW_NLB] = 1'b0; cw[CW_SUB] = 1'b1; end
            default: ;
          endcase
        end
        T6: begin
          case (bus.ir_opcode)
            OP_ADD: begin cw[CW_EU] = 1'b1; cw[CW_NLA] = 1'b0; end
            OP_SUB: begin cw[CW_EU] = 1'b1; cw[CW_NLA] = 1'b0; cw[CW_SUB] = 1'b1; end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  assign bus.Cp      = cw[CW_CP];
  assign bus.Ep      = cw[CW_EP];
  assign bus.nLm     = cw[CW_NLM];
  assign bus.Er      = cw[CW_ER];
  assign bus.nLi     = cw[CW_NLI];
  assign bus.Ei      = cw[CW_EI];
  assign bus.nLa     = cw[CW_NLA];
  assign bus.Ea      = cw[CW_EA];
  assign bus.nLb     = cw[CW_NLB];
  assign bus.Eu      = cw[CW_EU];
  assign bus.sub     = cw[CW_SUB];
  assign bus.nLo     = cw[CW_NLO];
  assign bus.nLp     = cw[CW_NLP];
  assign bus.halt    = halt_q;
  assign bus.t_state = t_state;

endmodule

// File: tb/tb_sap1_control_sequencer.sv
// tb/tb_sap1_control_sequencer.sv - directed self-checking bench for sap1_control_sequencer
module tb_sap1_control_sequencer;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  sap1_control_sequencer_if bus();

  sap1_control_sequencer #(.T_STATES(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Observed word order: Cp Ep nLm Er nLi Ei nLa Ea nLb Eu sub nLo nLp
  localparam logic [12:0] W_IDLE   = 13'b0_0_1_0_1_0_1_0_1_0_0_1_1;
  localparam logic [12:0] W_T1     = 13'b0_1_0_0_1_0_1_0_1_0_0_1_1;
  localparam logic [12:0] W_T2     = 13'b1_0_1_0_1_0_1_0_1_0_0_1_1;
  localparam logic [12:0] W_T3     = 13'b0_0_1_1_0_0_1_0_1_0_0_1_1;
  localparam logic [12:0] W_MAR_IR = 13'b0_0_0_0_1_1_1_0_1_0_0_1_1;
  localparam logic [12:0] W_ADD_T5 = 13'b0_0_1_1_1_0_1_0_0_0_0_1_1;
  localparam logic [12:0] W_ADD_T6 = 13'b0_0_1_0_1_0_0_0_1_1_0_1_1;
  localparam logic [12:0] W_SUB_T5 = 13'b0_0_1_1_1_0_1_0_0_0_1_1_1;
  localparam logic [12:0] W_SUB_T6 = 13'b0_0_1_0_1_0_0_0_1_1_1_1_1;
  localparam logic [12:0] W_LDA_T5 = 13'b0_0_1_1_1_0_0_0_1_0_0_1_1;
  localparam logic [12:0] W_JMP_T4 = 13'b0_0_1_0_1_1_1_0_1_0_0_1_0;
  localparam logic [12:0] W_OUT_T4 = 13'b0_0_1_0_1_0_1_1_1_0_0_0_1;

  function automatic logic [12:0] obs();
    return {bus.Cp, bus.Ep, bus.nLm, bus.Er, bus.nLi, bus.Ei, bus.nLa,
            bus.Ea, bus.nLb, bus.Eu, bus.sub, bus.nLo, bus.nLp};
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      checks++;
      if ($countones({bus.Ep, bus.Er, bus.Ei, bus.Ea, bus.Eu}) > 1) begin
        errors++;
        $display("FAIL onehot_enable: got Ep Er Ei Ea Eu=%b want at most one high",
                 {bus.Ep, bus.Er, bus.Ei, bus.Ea, bus.Eu});
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    bus.run = 1'b1;
    bus.ir_opcode = 4'h3;
    bus.CF = 1'b0;
    bus.ZF = 1'b0;
    tick();
    checks++;
    if (bus.t_state !== 6'b000001) begin errors++; $display("FAIL reset_t_state: got %b want 000001", bus.t_state); end
    checks++;
    if (bus.halt !== 1'b0) begin errors++; $display("FAIL reset_halt: got %b want 0", bus.halt); end
    checks++;
    if (obs() !== W_IDLE) begin errors++; $display("FAIL reset_strobes: got %b want %b", obs(), W_IDLE); end
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (obs() !== W_T1) begin errors++; $display("FAIL reset_release_t1: got %b want %b", obs(), W_T1); end
  endtask

  task automatic test_instr(input logic [3:0] op, input logic [12:0] e4,
                            input logic [12:0] e5, input logic [12:0] e6);
    logic [12:0] tbl [6];
    logic [5:0]  exp_t;
    tbl = '{W_T1, W_T2, W_T3, e4, e5, e6};
    bus.ir_opcode = op;
    #1;
    for (int i = 0; i < 6; i++) begin
      exp_t = 6'b000001 << i;
      checks++;
      if (bus.t_state !== exp_t) begin
        errors++; $display("FAIL instr_%h_t_state cycle %0d: got %b want %b", op, i, bus.t_state, exp_t);
      end
      checks++;
      if (obs() !== tbl[i]) begin
        errors++; $display("FAIL instr_%h_strobes T%0d: got %b want %b", op, i + 1, obs(), tbl[i]);
      end
      tick();
    end
    checks++;
    if (bus.t_state !== 6'b000001) begin
      errors++; $display("FAIL instr_%h_wrap: got %b want 000001", op, bus.t_state);
    end
  endtask

  task automatic test_jumps();
    // JC: CF high only across the T3->T4 edge, low again during T4
    bus.ir_opcode = 4'h5;
    bus.CF = 1'b0;
    tick(); tick();
    bus.CF = 1'b1;
    tick();
    bus.CF = 1'b0;
    #1;
    checks++;
    if (obs() !== W_JMP_T4) begin errors++; $display("FAIL jc_latched_taken: got %b want %b", obs(), W_JMP_T4); end
    tick(); tick(); tick();
    // JZ with ZF=0 and CF=1: never loads the PC
    bus.ir_opcode = 4'h6;
    bus.ZF = 1'b0;
    bus.CF = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      checks++;
      if (bus.nLp !== 1'b1) begin errors++; $display("FAIL jz_not_taken_nLp T%0d: got %b want 1", i + 1, bus.nLp); end
      tick();
    end
    // JC with CF=0: T4 idle
    bus.ir_opcode = 4'h5;
    bus.CF = 1'b0;
    tick(); tick(); tick();
    checks++;
    if (obs() !== W_IDLE) begin errors++; $display("FAIL jc_not_taken: got %b want %b", obs(), W_IDLE); end
    tick(); tick(); tick();
    // JZ with ZF=1: taken
    bus.ir_opcode = 4'h6;
    bus.ZF = 1'b1;
    tick(); tick(); tick();
    checks++;
    if (obs() !== W_JMP_T4) begin errors++; $display("FAIL jz_taken: got %b want %b", obs(), W_JMP_T4); end
    tick(); tick(); tick();
    bus.ZF = 1'b0;
  endtask

  task automatic test_stall();
    bus.ir_opcode = 4'h0;
    tick(); tick(); tick(); tick();
    bus.run = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (bus.t_state !== 6'b010000) begin errors++; $display("FAIL stall_t_state %0d: got %b want 010000", i, bus.t_state); end
      checks++;
      if (obs() !== W_IDLE) begin errors++; $display("FAIL stall_strobes %0d: got %b want %b", i, obs(), W_IDLE); end
      tick();
    end
    bus.run = 1'b1;
    #1;
    checks++;
    if (bus.t_state !== 6'b010000) begin errors++; $display("FAIL stall_resume_t: got %b want 010000", bus.t_state); end
    checks++;
    if (obs() !== W_LDA_T5) begin errors++; $display("FAIL stall_resume_t5: got %b want %b", obs(), W_LDA_T5); end
    tick();
    checks++;
    if (bus.t_state !== 6'b100000 || obs() !== W_IDLE) begin
      errors++; $display("FAIL stall_t6: got t=%b w=%b want t=100000 w=%b", bus.t_state, obs(), W_IDLE);
    end
    tick();
    checks++;
    if (bus.t_state !== 6'b000001) begin errors++; $display("FAIL stall_done: got %b want 000001", bus.t_state); end
  endtask

  task automatic test_halt();
    bus.ir_opcode = 4'hF;
    tick(); tick(); tick();
    checks++;
    if (bus.halt !== 1'b0 || obs() !== W_IDLE) begin
      errors++; $display("FAIL halt_t4: got halt=%b w=%b want halt=0 w=%b", bus.halt, obs(), W_IDLE);
    end
    tick();
    checks++;
    if (bus.halt !== 1'b1 || bus.t_state !== 6'b000000) begin
      errors++; $display("FAIL halt_enter: got halt=%b t=%b want halt=1 t=000000", bus.halt, bus.t_state);
    end
    for (int i = 0; i < 20; i++) begin
      bus.run = i[0];
      tick();
      checks++;
      if (bus.halt !== 1'b1 || bus.t_state !== 6'b000000 || obs() !== W_IDLE) begin
        errors++;
        $display("FAIL halt_hold %0d: got halt=%b t=%b w=%b want halt=1 t=000000 w=%b",
                 i, bus.halt, bus.t_state, obs(), W_IDLE);
      end
    end
    bus.run = 1'b1;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.halt !== 1'b0 || bus.t_state !== 6'b000001 || obs() !== W_IDLE) begin
      errors++; $display("FAIL halt_reset: got halt=%b t=%b w=%b want halt=0 t=000001 w=%b",
                         bus.halt, bus.t_state, obs(), W_IDLE);
    end
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (bus.t_state !== 6'b000001 || obs() !== W_T1) begin
      errors++; $display("FAIL halt_release: got t=%b w=%b want t=000001 w=%b", bus.t_state, obs(), W_T1);
    end
  endtask

  task automatic test_async_reset();
    bus.ir_opcode = 4'h1;
    tick(); tick(); tick(); tick(); tick();
    checks++;
    if (obs() !== W_ADD_T6) begin errors++; $display("FAIL async_pre_t6: got %b want %b", obs(), W_ADD_T6); end
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.t_state !== 6'b000001 || bus.halt !== 1'b0 || obs() !== W_IDLE) begin
      errors++; $display("FAIL async_assert: got t=%b halt=%b w=%b want t=000001 halt=0 w=%b",
                         bus.t_state, bus.halt, obs(), W_IDLE);
    end
    #1;
    rst = 1'b0;
    #1;
    checks++;
    if (bus.t_state !== 6'b000001 || obs() !== W_T1) begin
      errors++; $display("FAIL async_release: got t=%b w=%b want t=000001 w=%b", bus.t_state, obs(), W_T1);
    end
    tick();
    checks++;
    if (bus.t_state !== 6'b000010) begin errors++; $display("FAIL async_advance: got %b want 000010", bus.t_state); end
  endtask

  initial begin
    test_reset();
    test_instr(4'h3, W_IDLE, W_IDLE, W_IDLE);
    test_instr(4'h1, W_MAR_IR, W_ADD_T5, W_ADD_T6);
    test_instr(4'h2, W_MAR_IR, W_SUB_T5, W_SUB_T6);
    test_instr(4'h0, W_MAR_IR, W_LDA_T5, W_IDLE);
    test_instr(4'hE, W_OUT_T4, W_IDLE, W_IDLE);
    test_instr(4'h4, W_JMP_T4, W_IDLE, W_IDLE);
    test_jumps();
    test_stall();
    test_halt();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
